// File: rtl/e_mdu_pkg.sv
// rtl/e_mdu_pkg.sv - shared mult/div unit definitions
// Purpose: op codes, FSM state encoding, default latencies and counter width
//          shared by the E-stage mult/div unit and the hazard controller.
// Ports:   none (package).
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_t;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;
  localparam int MD_CNT_W       = 8;

  // Ops that occupy the unit for a multi-cycle computation.
  function automatic logic md_is_start(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - E-stage multiply/divide unit with HI/LO registers
// Purpose: fixed-latency MULT/MULTU/DIV/DIVU plus MTHI/MTLO/MFHI/MFLO access.
// Ports:
//   clk              - clock, rising edge
//   reset            - asynchronous active-high reset
//   E_md_op          - md operation code (md_op_t encoding)
//   E_md_start       - qualifies E_md_op; 0 means no operation
//   E_rs_data        - rs operand (dividend / multiplicand / MT source)
//   E_rt_data        - rt operand (divisor / multiplier)
//   E_md_busy        - computation in flight
//   E_md_start_issue - mult/div accepted this cycle (combinational)
//   E_md_out         - HI for MFHI, LO for MFLO, else 0 (combinational)
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_md_op,
  input  logic        E_md_start,
  input  logic [31:0] E_rs_data,
  input  logic [31:0] E_rt_data,
  output logic        E_md_busy,
  output logic        E_md_start_issue,
  output logic [31:0] E_md_out
);

  localparam logic [MD_CNT_W-1:0] CNT_ONE = MD_CNT_W'(1);

  md_state_t           state;
  logic [MD_CNT_W-1:0] cnt;
  logic [31:0]         hi, lo;
  logic [3:0]          op_q;
  logic [31:0]         rs_q, rt_q;
  logic                busy_q;

  logic [3:0]  op_eff;
  logic        start_ok;
  logic        is_signed, is_div;
  logic        rs_neg, rt_neg;
  logic [63:0] mul_a, mul_b, prod;
  logic [31:0] dvd, dvs, q_mag, r_mag, quot, rem;

  assign op_eff           = E_md_start ? E_md_op : MD_NONE;
  assign start_ok         = (state == MD_IDLE) && md_is_start(op_eff);
  assign E_md_start_issue = start_ok;
  assign E_md_busy        = busy_q;

  always_comb begin
    E_md_out = 32'd0;
    case (op_eff)
      MD_MFHI: E_md_out = hi;
      MD_MFLO: E_md_out = lo;
      default: E_md_out = 32'd0;
    endcase
  end

  // Arithmetic works only on latched operands so forwarding changes during
  // BUSY cannot disturb the result.
  assign is_signed = (op_q == MD_MULT) || (op_q == MD_DIV);
  assign is_div    = (op_q == MD_DIV)  || (op_q == MD_DIVU);
  assign rs_neg    = is_signed & rs_q[31];
  assign rt_neg    = is_signed & rt_q[31];

  // Low 64 bits of an extended product are the same for signed and unsigned.
  assign mul_a = {{32{rs_neg}}, rs_q};
  assign mul_b = {{32{rt_neg}}, rt_q};
  assign prod  = mul_a * mul_b;

  // Signed divide via magnitudes; 0x80000000 / -1 naturally yields
  // 0x80000000 rem 0. Divisor forced to 1 for rt=0 (result discarded).
  assign dvd   = rs_neg ? -rs_q : rs_q;
  assign dvs   = (rt_q == 32'd0) ? 32'd1 : (rt_neg ? -rt_q : rt_q);
  assign q_mag = dvd / dvs;
  assign r_mag = dvd % dvs;
  assign quot  = (rs_neg ^ rt_neg) ? -q_mag : q_mag;
  assign rem   = rs_neg ? -r_mag : r_mag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      op_q   <= MD_NONE;
      rs_q   <= 32'd0;
      rt_q   <= 32'd0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start_ok) begin
            op_q   <= op_eff;
            rs_q   <= E_rs_data;
            rt_q   <= E_rt_data;
            cnt    <= ((op_eff == MD_DIV) || (op_eff == MD_DIVU)) ?
                      MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES);
            state  <= MD_BUSY;
            busy_q <= 1'b1;
          end else if (op_eff == MD_MTHI) begin
            hi <= E_rs_data;
          end else if (op_eff == MD_MTLO) begin
            lo <= E_rs_data;
          end
        end
        MD_BUSY: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state  <= MD_IDLE;
            busy_q <= 1'b0;
            if (!is_div) begin
              hi <= prod[63:32];
              lo <= prod[31:0];
            end else if (rt_q != 32'd0) begin
              hi <= rem;
              lo <= quot;
            end
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - self-checking bench for e_mdu
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_md_op;
  logic        E_md_start;
  logic [31:0] E_rs_data;
  logic [31:0] E_rt_data;
  logic        E_md_busy;
  logic        E_md_start_issue;
  logic [31:0] E_md_out;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] sb_q[$];
  logic [31:0] mod_hi = 32'd0;
  logic [31:0] mod_lo = 32'd0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk              (clk),
    .reset            (reset),
    .E_md_op          (E_md_op),
    .E_md_start       (E_md_start),
    .E_rs_data        (E_rs_data),
    .E_rt_data        (E_rt_data),
    .E_md_busy        (E_md_busy),
    .E_md_start_issue (E_md_start_issue),
    .E_md_out         (E_md_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%h, expected 0x%h", tag, obs, exp);
    end
  endtask

  // Reference model, independent of the RTL datapath.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] h,
                                        input logic [31:0] l);
    longint p;
    int q, r;
    case (op)
      MD_MULT: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
      end
      MD_MULTU: return {32'd0, a} * {32'd0, b};
      MD_DIV: begin
        if (b == 32'd0) return {h, l};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      MD_DIVU: begin
        if (b == 32'd0) return {h, l};
        return {a % b, a / b};
      end
      default: return {h, l};
    endcase
  endfunction

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    E_md_op = MD_MFHI; E_md_start = 1'b1;
    #1 chk({tag, ".hi"}, E_md_out, exp_hi);
    E_md_op = MD_MFLO;
    #1 chk({tag, ".lo"}, E_md_out, exp_lo);
    E_md_op = MD_NONE; E_md_start = 1'b0;
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] data);
    @(negedge clk);
    E_md_op = op; E_md_start = 1'b1; E_rs_data = data;
    @(negedge clk);
    E_md_op = MD_NONE; E_md_start = 1'b0;
    #1;
  endtask

  // Issue one mult/div, track busy cycles, optionally peek HI/LO or present
  // competing ops while busy, then pop the scoreboard and compare HI/LO.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input int n, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int peek_at, input int inject_at);
    int busy_cnt;
    logic [63:0] exp;
    @(negedge clk);
    E_md_op = op; E_md_start = 1'b1; E_rs_data = rs; E_rt_data = rt;
    #1 chk({tag, ".issue"}, 32'(E_md_start_issue), 32'd1);
    sb_q.push_back({exp_hi, exp_lo});
    @(negedge clk);
    E_md_op = MD_NONE; E_md_start = 1'b0; E_rs_data = $urandom; E_rt_data = $urandom;
    #1;
    busy_cnt = 0;
    for (int i = 0; i < n + 4; i++) begin
      if (!E_md_busy) break;
      busy_cnt++;
      if (i == peek_at) read_hilo({tag, ".peek"}, mod_hi, mod_lo);
      if (i == inject_at) begin
        E_md_op = MD_MULT; E_md_start = 1'b1; E_rs_data = 32'd100; E_rt_data = 32'd100;
        #1 chk({tag, ".issue_busy"}, 32'(E_md_start_issue), 32'd0);
      end
      if (inject_at >= 0 && i == inject_at + 1) begin
        E_md_op = MD_MTLO; E_md_start = 1'b1; E_rs_data = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      E_md_op = MD_NONE; E_md_start = 1'b0;
      #1;
    end
    chk({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(n));
    exp = sb_q.pop_front();
    read_hilo(tag, exp[63:32], exp[31:0]);
    mod_hi = exp[63:32];
    mod_lo = exp[31:0];
  endtask

  initial begin
    logic [3:0]  ops [4];
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    logic [63:0] e;
    ops = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};

    reset = 1'b1; E_md_op = MD_NONE; E_md_start = 1'b0; E_rs_data = 32'd0; E_rt_data = 32'd0;
    repeat (3) @(negedge clk);
    #1 chk("rst.busy", 32'(E_md_busy), 32'd0);
    read_hilo("rst", 32'd0, 32'd0);
    E_md_op = MD_MFHI; E_md_start = 1'b0;
    #1 chk("rst.out_nostart", E_md_out, 32'd0);
    E_md_op = MD_NONE;
    @(posedge clk); #2 reset = 1'b0;

    run_op("mult_neg", MD_MULT, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, -1, -1);
    run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE, -1, -1);
    run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 2, -1);

    mt(MD_MTHI, 32'h0000_1234);
    mod_hi = 32'h0000_1234;
    read_hilo("mthi", mod_hi, mod_lo);
    run_op("divu_zero", MD_DIVU, 32'd5, 32'd0, 10, 32'h0000_1234, mod_lo, -1, -1);

    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, -1, -1);
    run_op("mult_busy_ign", MD_MULT, 32'd7, 32'd6, 5, 32'd0, 32'd42, -1, 1);

    for (int k = 0; k < 8; k++) begin
      rop = ops[k % 4];
      ra = $urandom;
      rb = (k == 6) ? 32'd0 : ((k % 2 == 0) ? $urandom : $urandom_range(1, 1000));
      e = model(rop, ra, rb, mod_hi, mod_lo);
      run_op($sformatf("rnd%0d", k), rop, ra, rb,
             (rop == MD_DIV || rop == MD_DIVU) ? 10 : 5, e[63:32], e[31:0], -1, -1);
    end

    // Abort a divide with an asynchronous reset between edges at t+4.
    @(negedge clk);
    E_md_op = MD_DIV; E_md_start = 1'b1; E_rs_data = 32'd100; E_rt_data = 32'd7;
    #1 chk("abort.issue", 32'(E_md_start_issue), 32'd1);
    @(negedge clk);
    E_md_op = MD_NONE; E_md_start = 1'b0;
    #1 chk("abort.busy_t1", 32'(E_md_busy), 32'd1);
    @(negedge clk); @(negedge clk);
    @(posedge clk); #2 reset = 1'b1;
    #1 chk("abort.busy_drop", 32'(E_md_busy), 32'd0);
    read_hilo("abort.rst", 32'd0, 32'd0);
    mod_hi = 32'd0; mod_lo = 32'd0;
    @(posedge clk); #2 reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1 chk($sformatf("abort.idle%0d", i), 32'(E_md_busy), 32'd0);
    end
    read_hilo("abort.after", 32'd0, 32'd0);

    // Start accepted on the very first edge after reset release.
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    run_op("post_rst", MD_MULTU, 32'd3, 32'd4, 5, 32'd0, 32'd12, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
